layer_compositor: RTL and testbench
===================================

// Module: layer_compositor
// PURPOSE
//  Pipelined, parametrised pixel compositor for the VGA path. Replaces per-pixel combinational colour selection.
//  Layers, highest priority first: result screen, title screen, NUM_BALLS note balls, character sprite
//  (chroma-keyed), background.
//  Adds a frame-synchronous fade state machine (play -> fade out -> result fade in) and registered RGB output.
//  Sits between the sprite ROMs/VGA controller and the DAC pins.
// PARAMETERS
//  NUM_BALLS    4        number of note-ball channels (1..8)
//  FADE_STEP    2        frames per intensity step during fades (>=1)
//  KEY_RGB      12'h2B4  sprite chroma-key colour {R,G,B}, treated as transparent
//  SPR_W/SPR_H  200/266  character sprite window size in pixels
//  THR_HI/THR_LO 250/100 score thresholds: SUPERB / OK / TRY AGAIN
// PORTS
//  VGA_Clk      in   1            pixel clock
//  Reset        in   1            synchronous, active-high
//  frame_start  in   1            one-cycle pulse at start of vertical blank
//  blank        in   1            1 = active video (VGA controller convention)
//  DrawX,DrawY  in   10 each      current pixel coordinate
//  JoeX,JoeY    in   10 each      sprite window origin
//  ball_x,ball_y,ball_r in NUM_BALLS*10 each  packed per-ball centre/radius, ball i at [10i+9:10i]
//  ball_en      in   NUM_BALLS    per-ball visible
//  ball_hit     in   NUM_BALLS    per-ball "activated" colour select
//  start        in   2            00 = gameplay, else title screen shown
//  end_screen   in   1            level: game finished
//  score        in   16           final score, sampled on fade entry
//  spr_rgb,title_rgb,bg_rgb  in   12 each  layer pixels, valid 1 cycle after DrawX/DrawY
//  res_rgb      in   3*12         result pixels {superb,ok,tryagain}, same timing
//  Red,Green,Blue out 4 each      registered output colour
//  result_code  out  2            0 none, 1 tryagain, 2 ok, 3 superb
//  fade_busy    out  1            1 while in FADE_OUT or FADE_IN
// BEHAVIOUR
//  Pipeline, total latency 2 cycles from DrawX/DrawY to RGB:
//   S1: register per-ball hit (dx^2+dy^2 <= r^2, 21-bit unsigned) and sprite window test (6<=dx<=SPR_W, 3<=dy<=SPR_H).
//       dx,dy are signed 11-bit; negative differences are outside the window. blank is delayed with the data.
//   S2: select layer using S1 flags and the 1-cycle-late *_rgb inputs, apply intensity, register outputs.
//  Ball colour: lowest-index hit ball wins. Ball 0 = 0x05F. Ball i>0 = 0x0F5 if ball_hit[i], else 0xF50.
//   Ball ignored when ball_en[i]=0 or ball_r[i]=0.
//  Sprite: shown only in window and spr_rgb != KEY_RGB; else background.
//  Outputs 0 while delayed blank = 0.
//  FSM (state and level change only on frame_start, except Reset):
//   PLAY: lvl=15. end_screen=1 -> FADE_OUT; latch score into result_code.
//   FADE_OUT: gameplay image scaled; lvl-- every FADE_STEP frames; lvl reaches 0 -> FADE_IN.
//   FADE_IN: result image scaled; lvl++ every FADE_STEP frames; lvl reaches 15 -> RESULT.
//   RESULT: result image at full level.
//   end_screen=0 in any non-PLAY state -> PLAY, lvl=15, result_code=0 (abort mid-fade allowed).
//  Scaling: out = (c*(lvl+1))>>4; lvl=15 is identity, lvl=0 gives c>>4 = 0.
//  Title screen (start!=0) overrides balls/sprite in PLAY only; during fades and RESULT the FSM owns the image.
//  result_code: score>=THR_HI -> 3; score>=THR_LO -> 2; else 1. Held until return to PLAY.
//  Reset: state=PLAY, lvl=15, frame-step counter=0, pipeline flags=0, RGB=0, result_code=0, fade_busy=0.
//  end_screen and frame_start asserted in the same cycle: transition is taken in that cycle.
// TESTING
//  Ball 0 at (100,100) r=5, DrawX=103, DrawY=104 -> RGB 0x05F exactly 2 cycles later. (104,104) -> background.
//  Balls 0 and 2 overlap, ball_hit[2]=1 -> ball 0 colour wins. Disable ball 0 -> 0x0F5.
//  Sprite pixel = KEY_RGB inside window -> bg_rgb. JoeX=DrawX+1 (negative dx) -> bg_rgb.
//  end_screen=1, score=180, FADE_STEP=2 -> result_code=2 at next frame_start.
//   lvl reaches 0 after 30 frames; RESULT after 60 frames; fade_busy high throughout.
//  end_screen dropped mid FADE_IN -> PLAY at next frame_start, lvl=15, result_code=0.
//  Reset asserted mid FADE_OUT -> all outputs 0 next cycle, state PLAY; blank=0 -> RGB=0.

Source files
------------

// File: rtl/layer_compositor.sv
// ---------------------------------------------------------------------------
// layer_compositor
// Pipelined pixel compositor for the VGA path. Picks one of five layers
// (result screen, title screen, note balls, chroma-keyed character sprite,
// background), scales it by a frame-synchronous fade level and drives
// registered RGB to the DAC pins.
//
// Ports
//   VGA_Clk                 pixel clock
//   Reset                   synchronous, active-high
//   frame_start             one-cycle pulse at start of vertical blank
//   blank                   1 = active video
//   DrawX, DrawY            current pixel coordinate
//   JoeX, JoeY              sprite window origin
//   ball_x/ball_y/ball_r    packed per-ball centre/radius, ball i at [10i+9:10i]
//   ball_en, ball_hit       per-ball visible / activated-colour select
//   start                   00 = gameplay, otherwise title screen
//   end_screen              level: game finished
//   score                   final score, classified on fade entry
//   spr_rgb/title_rgb/bg_rgb layer pixels, one cycle after DrawX/DrawY
//   res_rgb                 result pixels {superb, ok, tryagain}, same timing
//   Red, Green, Blue        registered output colour (2 cycles after DrawX/DrawY)
//   result_code             0 none, 1 try again, 2 ok, 3 superb
//   fade_busy               1 while fading out or in
// ---------------------------------------------------------------------------
module layer_compositor #(
    parameter int          NUM_BALLS = 4,
    parameter int          FADE_STEP = 2,
    parameter logic [11:0] KEY_RGB   = 12'h2B4,
    parameter int          SPR_W     = 200,
    parameter int          SPR_H     = 266,
    parameter int          THR_HI    = 250,
    parameter int          THR_LO    = 100
) (
    input  logic                   VGA_Clk,
    input  logic                   Reset,
    input  logic                   frame_start,
    input  logic                   blank,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic [9:0]             JoeX,
    input  logic [9:0]             JoeY,
    input  logic [NUM_BALLS*10-1:0] ball_x,
    input  logic [NUM_BALLS*10-1:0] ball_y,
    input  logic [NUM_BALLS*10-1:0] ball_r,
    input  logic [NUM_BALLS-1:0]   ball_en,
    input  logic [NUM_BALLS-1:0]   ball_hit,
    input  logic [1:0]             start,
    input  logic                   end_screen,
    input  logic [15:0]            score,
    input  logic [11:0]            spr_rgb,
    input  logic [11:0]            title_rgb,
    input  logic [11:0]            bg_rgb,
    input  logic [35:0]            res_rgb,
    output logic [3:0]             Red,
    output logic [3:0]             Green,
    output logic [3:0]             Blue,
    output logic [1:0]             result_code,
    output logic                   fade_busy
);

    typedef enum logic [1:0] {
        ST_PLAY     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_FADE_IN  = 2'd2,
        ST_RESULT   = 2'd3
    } state_t;

    localparam int                  CNT_W     = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
    localparam logic [CNT_W-1:0]    STEP_LAST = CNT_W'(FADE_STEP - 1);
    localparam logic signed [10:0]  SPR_W_S   = 11'(SPR_W);
    localparam logic signed [10:0]  SPR_H_S   = 11'(SPR_H);

    // c * (lvl + 1) / 16: lvl 15 passes the channel through, lvl 0 blacks it out
    function automatic logic [3:0] scale_ch(input logic [3:0] c, input logic [3:0] lvl);
        logic [7:0] prod;
        prod = {4'd0, c} * ({4'd0, lvl} + 8'd1);
        return 4'(prod >> 4);
    endfunction

    function automatic logic [1:0] classify(input logic [15:0] s);
        logic [1:0] code;
        if (s >= 16'(THR_HI)) begin
            code = 2'd3;
        end else if (s >= 16'(THR_LO)) begin
            code = 2'd2;
        end else begin
            code = 2'd1;
        end
        return code;
    endfunction

    // ---------------- stage 1: geometry tests ----------------
    logic [NUM_BALLS-1:0] ball_in_s;
    logic [NUM_BALLS-1:0] ball_in_r;
    logic [NUM_BALLS-1:0] ball_sel_r;
    logic signed [10:0]   spr_dx_s;
    logic signed [10:0]   spr_dy_s;
    logic                 spr_win_s;
    logic                 spr_win_r;
    logic                 blank_r;

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
        logic [10:0] dx_s;
        logic [10:0] dy_s;
        logic [9:0]  adx_s;
        logic [9:0]  ady_s;
        logic [9:0]  rad_s;
        logic [20:0] dist_s;
        logic [20:0] rad_sq_s;

        // Squared distance from pixel to ball centre against squared radius
        always_comb begin
            rad_s    = ball_r[10*g +: 10];
            dx_s     = {1'b0, DrawX} - {1'b0, ball_x[10*g +: 10]};
            dy_s     = {1'b0, DrawY} - {1'b0, ball_y[10*g +: 10]};
            adx_s    = dx_s[10] ? 10'(-dx_s) : dx_s[9:0];
            ady_s    = dy_s[10] ? 10'(-dy_s) : dy_s[9:0];
            dist_s   = ({11'd0, adx_s} * {11'd0, adx_s}) + ({11'd0, ady_s} * {11'd0, ady_s});
            rad_sq_s = {11'd0, rad_s} * {11'd0, rad_s};
            ball_in_s[g] = ball_en[g] && (rad_s != 10'd0) && (dist_s <= rad_sq_s);
        end
    end

    // Sprite window test; a negative offset can never satisfy the lower bounds
    always_comb begin
        spr_dx_s  = $signed({1'b0, DrawX} - {1'b0, JoeX});
        spr_dy_s  = $signed({1'b0, DrawY} - {1'b0, JoeY});
        spr_win_s = (spr_dx_s >= 11'sd6) && (spr_dx_s <= SPR_W_S) &&
                    (spr_dy_s >= 11'sd3) && (spr_dy_s <= SPR_H_S);
    end

    // Stage 1 register: geometry flags travel with the delayed blank
    always_ff @(posedge VGA_Clk) begin
        if (Reset) begin
            ball_in_r  <= {NUM_BALLS{1'b0}};
            ball_sel_r <= {NUM_BALLS{1'b0}};
            spr_win_r  <= 1'b0;
            blank_r    <= 1'b0;
        end else begin
            ball_in_r  <= ball_in_s;
            ball_sel_r <= ball_hit;
            spr_win_r  <= spr_win_s;
            blank_r    <= blank;
        end
    end

    // ---------------- fade FSM ----------------
    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       lvl_r;
    logic [3:0]       lvl_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [1:0]       result_code_r;
    logic [1:0]       code_nxt_s;
    logic             fade_busy_r;
    logic             fade_busy_nxt_s;

    // FSM state register with level, frame counter and result code
    always_ff @(posedge VGA_Clk) begin
        if (Reset) begin
            state_r       <= ST_PLAY;
            lvl_r         <= 4'd15;
            cnt_r         <= {CNT_W{1'b0}};
            result_code_r <= 2'd0;
            fade_busy_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            lvl_r         <= lvl_nxt_s;
            cnt_r         <= cnt_nxt_s;
            result_code_r <= code_nxt_s;
            fade_busy_r   <= fade_busy_nxt_s;
        end
    end

    // FSM next state: everything moves only on frame_start
    always_comb begin
        state_nxt_s = state_r;
        lvl_nxt_s   = lvl_r;
        cnt_nxt_s   = cnt_r;
        code_nxt_s  = result_code_r;
        if (frame_start) begin
            if ((state_r != ST_PLAY) && !end_screen) begin
                // abort from any fade/result state
                state_nxt_s = ST_PLAY;
                lvl_nxt_s   = 4'd15;
                cnt_nxt_s   = {CNT_W{1'b0}};
                code_nxt_s  = 2'd0;
            end else begin
                case (state_r)
                    ST_PLAY: begin
                        lvl_nxt_s = 4'd15;
                        cnt_nxt_s = {CNT_W{1'b0}};
                        if (end_screen) begin
                            state_nxt_s = ST_FADE_OUT;
                            code_nxt_s  = classify(score);
                        end else begin
                            state_nxt_s = ST_PLAY;
                            code_nxt_s  = 2'd0;
                        end
                    end
                    ST_FADE_OUT: begin
                        if (cnt_r == STEP_LAST) begin
                            cnt_nxt_s   = {CNT_W{1'b0}};
                            lvl_nxt_s   = lvl_r - 4'd1;
                            state_nxt_s = (lvl_r == 4'd1) ? ST_FADE_IN : ST_FADE_OUT;
                        end else begin
                            cnt_nxt_s   = cnt_r + CNT_W'(1'b1);
                        end
                    end
                    ST_FADE_IN: begin
                        if (cnt_r == STEP_LAST) begin
                            cnt_nxt_s   = {CNT_W{1'b0}};
                            lvl_nxt_s   = lvl_r + 4'd1;
                            state_nxt_s = (lvl_r == 4'd14) ? ST_RESULT : ST_FADE_IN;
                        end else begin
                            cnt_nxt_s   = cnt_r + CNT_W'(1'b1);
                        end
                    end
                    ST_RESULT: begin
                        state_nxt_s = ST_RESULT;
                    end
                    default: begin
                        state_nxt_s = ST_PLAY;
                        lvl_nxt_s   = 4'd15;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        code_nxt_s  = 2'd0;
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM outputs, decoded from the next state so they register alongside it
    always_comb begin
        case (state_nxt_s)
            ST_FADE_OUT: fade_busy_nxt_s = 1'b1;
            ST_FADE_IN:  fade_busy_nxt_s = 1'b1;
            default:     fade_busy_nxt_s = 1'b0;
        endcase
    end

    // ---------------- stage 2: layer select and intensity ----------------
    logic [11:0] ball_rgb_s;
    logic [11:0] game_rgb_s;
    logic [11:0] res_pick_s;
    logic [11:0] img_rgb_s;
    logic [3:0]  red_r;
    logic [3:0]  green_r;
    logic [3:0]  blue_r;

    // Layer select; walking from the top index down leaves the lowest hit ball
    always_comb begin
        ball_rgb_s = 12'h000;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            ball_rgb_s = !ball_in_r[i] ? ball_rgb_s :
                         (i == 0)      ? 12'h05F :
                         ball_sel_r[i] ? 12'h0F5 : 12'hF50;
        end

        if (ball_in_r != {NUM_BALLS{1'b0}}) begin
            game_rgb_s = ball_rgb_s;
        end else if (spr_win_r && (spr_rgb != KEY_RGB)) begin
            game_rgb_s = spr_rgb;
        end else begin
            game_rgb_s = bg_rgb;
        end

        case (result_code_r)
            2'd3:    res_pick_s = res_rgb[35:24];
            2'd2:    res_pick_s = res_rgb[23:12];
            2'd1:    res_pick_s = res_rgb[11:0];
            default: res_pick_s = 12'h000;
        endcase

        case (state_r)
            ST_PLAY:     img_rgb_s = (start != 2'b00) ? title_rgb : game_rgb_s;
            ST_FADE_OUT: img_rgb_s = game_rgb_s;
            ST_FADE_IN:  img_rgb_s = res_pick_s;
            ST_RESULT:   img_rgb_s = res_pick_s;
            default:     img_rgb_s = 12'h000;
        endcase
    end

    // Stage 2 register: scaled colour, forced black outside active video
    always_ff @(posedge VGA_Clk) begin
        if (Reset) begin
            red_r   <= 4'd0;
            green_r <= 4'd0;
            blue_r  <= 4'd0;
        end else if (!blank_r) begin
            red_r   <= 4'd0;
            green_r <= 4'd0;
            blue_r  <= 4'd0;
        end else begin
            red_r   <= scale_ch(img_rgb_s[11:8], lvl_r);
            green_r <= scale_ch(img_rgb_s[7:4],  lvl_r);
            blue_r  <= scale_ch(img_rgb_s[3:0],  lvl_r);
        end
    end

    assign Red         = red_r;
    assign Green       = green_r;
    assign Blue        = blue_r;
    assign result_code = result_code_r;
    assign fade_busy   = fade_busy_r;

endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;

    localparam logic [11:0] KEY   = 12'h2B4;
    localparam logic [11:0] BG    = 12'h123;
    localparam logic [11:0] BG2   = 12'hF84;
    localparam logic [11:0] TITLE = 12'h9AC;
    localparam logic [11:0] SPR   = 12'h7C1;
    localparam logic [11:0] R_SUP = 12'hE81;
    localparam logic [11:0] R_OK  = 12'h6D2;
    localparam logic [11:0] R_TRY = 12'h35A;
    localparam int          NV    = 20;

    logic        VGA_Clk = 1'b0;
    logic        Reset, frame_start, blank, end_screen;
    logic [9:0]  DrawX, DrawY, JoeX, JoeY;
    logic [39:0] ball_x, ball_y, ball_r;
    logic [3:0]  ball_en, ball_hit;
    logic [1:0]  start;
    logic [15:0] score;
    logic [11:0] spr_rgb, title_rgb, bg_rgb;
    logic [35:0] res_rgb;
    logic [3:0]  Red, Green, Blue;
    logic [1:0]  result_code;
    logic        fade_busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic [9:0]  jx;
        logic [3:0]  en;
        logic [3:0]  hit;
        logic [11:0] spr;
        logic [1:0]  st;
        logic        blk;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t tab [NV];

    layer_compositor dut (
        .VGA_Clk(VGA_Clk), .Reset(Reset), .frame_start(frame_start), .blank(blank),
        .DrawX(DrawX), .DrawY(DrawY), .JoeX(JoeX), .JoeY(JoeY),
        .ball_x(ball_x), .ball_y(ball_y), .ball_r(ball_r),
        .ball_en(ball_en), .ball_hit(ball_hit), .start(start),
        .end_screen(end_screen), .score(score),
        .spr_rgb(spr_rgb), .title_rgb(title_rgb), .bg_rgb(bg_rgb), .res_rgb(res_rgb),
        .Red(Red), .Green(Green), .Blue(Blue),
        .result_code(result_code), .fade_busy(fade_busy)
    );

    // pixel clock
    always #5 VGA_Clk = ~VGA_Clk;

    function automatic vec_t mk(input logic [9:0] dx, input logic [9:0] dy, input logic [9:0] jx,
                                input logic [3:0] en, input logic [3:0] hit, input logic [11:0] spr,
                                input logic [1:0] st, input logic blk, input logic [11:0] e);
        vec_t v;
        v.dx = dx; v.dy = dy; v.jx = jx; v.en = en; v.hit = hit;
        v.spr = spr; v.st = st; v.blk = blk; v.exp_rgb = e;
        return v;
    endfunction

    // reference fade scaling, one channel at a time
    function automatic logic [11:0] scl(input logic [11:0] c, input int lvl);
        int r, g, b;
        r = (int'(c[11:8]) * (lvl + 1)) / 16;
        g = (int'(c[7:4])  * (lvl + 1)) / 16;
        b = (int'(c[3:0])  * (lvl + 1)) / 16;
        return {r[3:0], g[3:0], b[3:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp_v);
        end
    endtask

    task automatic pulse();
        @(negedge VGA_Clk) frame_start = 1'b1;
        @(negedge VGA_Clk) frame_start = 1'b0;
        repeat (2) @(negedge VGA_Clk);
    endtask

    logic [11:0] exp_img;
    int          lvl_m;

    initial begin
        Reset = 1'b1; frame_start = 1'b0; blank = 1'b1; end_screen = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0; JoeX = 10'd50; JoeY = 10'd60;
        ball_x = {10'd500, 10'd102, 10'd300, 10'd100};
        ball_y = {10'd400, 10'd102, 10'd300, 10'd100};
        ball_r = {10'd3,   10'd10,  10'd0,   10'd5};
        ball_en = 4'b0000; ball_hit = 4'b0000; start = 2'b00; score = 16'd0;
        spr_rgb = KEY; title_rgb = TITLE; bg_rgb = BG; res_rgb = {R_SUP, R_OK, R_TRY};

        tab[0]  = mk(10'd103, 10'd104, 10'd50,   4'b0001, 4'b0000, KEY, 2'd0, 1'b1, 12'h05F);
        tab[1]  = mk(10'd104, 10'd104, 10'd50,   4'b0001, 4'b0000, KEY, 2'd0, 1'b1, BG);
        tab[2]  = mk(10'd103, 10'd104, 10'd50,   4'b0101, 4'b0100, KEY, 2'd0, 1'b1, 12'h05F);
        tab[3]  = mk(10'd103, 10'd104, 10'd50,   4'b0100, 4'b0100, KEY, 2'd0, 1'b1, 12'h0F5);
        tab[4]  = mk(10'd103, 10'd104, 10'd50,   4'b0100, 4'b0000, KEY, 2'd0, 1'b1, 12'hF50);
        tab[5]  = mk(10'd300, 10'd300, 10'd50,   4'b0010, 4'b0010, KEY, 2'd0, 1'b1, BG);
        tab[6]  = mk(10'd503, 10'd400, 10'd50,   4'b1000, 4'b1000, KEY, 2'd0, 1'b1, 12'h0F5);
        tab[7]  = mk(10'd503, 10'd401, 10'd50,   4'b1000, 4'b1000, KEY, 2'd0, 1'b1, BG);
        tab[8]  = mk(10'd56,  10'd63,  10'd50,   4'b0000, 4'b0000, SPR, 2'd0, 1'b1, SPR);
        tab[9]  = mk(10'd55,  10'd63,  10'd50,   4'b0000, 4'b0000, SPR, 2'd0, 1'b1, BG);
        tab[10] = mk(10'd250, 10'd326, 10'd50,   4'b0000, 4'b0000, SPR, 2'd0, 1'b1, SPR);
        tab[11] = mk(10'd251, 10'd326, 10'd50,   4'b0000, 4'b0000, SPR, 2'd0, 1'b1, BG);
        tab[12] = mk(10'd56,  10'd62,  10'd50,   4'b0000, 4'b0000, SPR, 2'd0, 1'b1, BG);
        tab[13] = mk(10'd100, 10'd100, 10'd101,  4'b0000, 4'b0000, SPR, 2'd0, 1'b1, BG);
        tab[14] = mk(10'd0,   10'd100, 10'd1000, 4'b0000, 4'b0000, SPR, 2'd0, 1'b1, BG);
        tab[15] = mk(10'd100, 10'd100, 10'd50,   4'b0001, 4'b0000, SPR, 2'd0, 1'b1, 12'h05F);
        tab[16] = mk(10'd100, 10'd100, 10'd50,   4'b0001, 4'b0000, SPR, 2'd1, 1'b1, TITLE);
        tab[17] = mk(10'd700, 10'd10,  10'd50,   4'b0000, 4'b0000, SPR, 2'd2, 1'b1, TITLE);
        tab[18] = mk(10'd100, 10'd100, 10'd50,   4'b0001, 4'b0000, SPR, 2'd0, 1'b0, 12'h000);
        tab[19] = mk(10'd110, 10'd100, 10'd50,   4'b0101, 4'b0000, SPR, 2'd0, 1'b1, 12'hF50);

        // reset state
        repeat (3) @(negedge VGA_Clk);
        check("reset_rgb", {Red, Green, Blue}, 12'h000);
        check("reset_code", result_code, 2'd0);
        check("reset_busy", fade_busy, 1'b0);
        Reset = 1'b0;

        // table-driven compositing in PLAY at full level
        for (int i = 0; i < NV; i++) begin
            DrawX = tab[i].dx; DrawY = tab[i].dy; JoeX = tab[i].jx;
            ball_en = tab[i].en; ball_hit = tab[i].hit; spr_rgb = tab[i].spr;
            start = tab[i].st; blank = tab[i].blk;
            repeat (3) @(negedge VGA_Clk);
            check($sformatf("vec%0d", i), {Red, Green, Blue}, tab[i].exp_rgb);
        end

        // two-cycle latency from coordinate to RGB
        DrawX = 10'd104; DrawY = 10'd104; JoeX = 10'd50; ball_en = 4'b0001; ball_hit = 4'b0000;
        spr_rgb = KEY; start = 2'd0; blank = 1'b1;
        repeat (3) @(negedge VGA_Clk);
        DrawX = 10'd103;
        @(negedge VGA_Clk);
        check("lat_1cyc", {Red, Green, Blue}, BG);
        @(negedge VGA_Clk);
        check("lat_2cyc", {Red, Green, Blue}, 12'h05F);

        // fade sequence on a plain background pixel
        DrawX = 10'd600; DrawY = 10'd10; ball_en = 4'b0000; bg_rgb = BG2;
        repeat (3) @(negedge VGA_Clk);
        check("play_full", {Red, Green, Blue}, BG2);
        end_screen = 1'b1; score = 16'd180;
        pulse();
        check("entry_code", result_code, 2'd2);
        check("entry_busy", fade_busy, 1'b1);
        check("entry_rgb", {Red, Green, Blue}, BG2);
        for (int k = 1; k <= 60; k++) begin
            pulse();
            if (k <= 30) lvl_m = 15 - k / 2;
            else         lvl_m = (k - 30) / 2;
            exp_img = (k < 30) ? BG2 : R_OK;
            check($sformatf("fade_rgb_k%0d", k), {Red, Green, Blue}, scl(exp_img, lvl_m));
            check($sformatf("fade_busy_k%0d", k), fade_busy, (k < 60) ? 1'b1 : 1'b0);
        end
        check("result_code_held", result_code, 2'd2);

        // leave RESULT
        end_screen = 1'b0;
        pulse();
        check("back_busy", fade_busy, 1'b0);
        check("back_code", result_code, 2'd0);
        check("back_rgb", {Red, Green, Blue}, BG2);

        // end_screen without frame_start must not move the FSM
        @(negedge VGA_Clk) end_screen = 1'b1; score = 16'd300;
        repeat (4) @(negedge VGA_Clk);
        check("nofs_busy", fade_busy, 1'b0);
        check("nofs_code", result_code, 2'd0);
        pulse();
        check("sup_code", result_code, 2'd3);
        for (int k = 1; k <= 35; k++) pulse();
        check("midin_rgb", {Red, Green, Blue}, scl(R_SUP, 2));
        check("midin_busy", fade_busy, 1'b1);

        // abort mid fade-in: waits for the next frame
        end_screen = 1'b0;
        repeat (3) @(negedge VGA_Clk);
        check("abort_wait_busy", fade_busy, 1'b1);
        pulse();
        check("abort_busy", fade_busy, 1'b0);
        check("abort_code", result_code, 2'd0);
        check("abort_rgb", {Red, Green, Blue}, BG2);

        // score thresholds
        begin
            logic [15:0] sc [6];
            logic [1:0]  cd [6];
            sc = '{16'd250, 16'd249, 16'd100, 16'd99, 16'd0, 16'd65535};
            cd = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3};
            for (int i = 0; i < 6; i++) begin
                end_screen = 1'b1; score = sc[i];
                pulse();
                check($sformatf("thr_%0d", sc[i]), result_code, cd[i]);
                end_screen = 1'b0;
                pulse();
            end
        end

        // reset in the middle of a fade-out
        end_screen = 1'b1; score = 16'd50;
        pulse();
        for (int k = 0; k < 5; k++) pulse();
        check("pre_rst_busy", fade_busy, 1'b1);
        check("pre_rst_code", result_code, 2'd1);
        @(negedge VGA_Clk) Reset = 1'b1;
        @(negedge VGA_Clk);
        check("rst_rgb", {Red, Green, Blue}, 12'h000);
        check("rst_code", result_code, 2'd0);
        check("rst_busy", fade_busy, 1'b0);
        end_screen = 1'b0;
        Reset = 1'b0;
        repeat (3) @(negedge VGA_Clk);
        check("post_rst_rgb", {Red, Green, Blue}, BG2);
        check("post_rst_busy", fade_busy, 1'b0);
        blank = 1'b0;
        repeat (3) @(negedge VGA_Clk);
        check("blank_rgb", {Red, Green, Blue}, 12'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
